imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that writes the instruction memory and holds the pipeline until a program image is complete. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It issues one instruction-memory write per word and verifies an XOR checksum. It is the write side of the instruction memory that the fetch stage reads, and it drives the core hold that keeps the pipeline in reset during loading.

## Interface
- ADDR_WIDTH, 8: word-address width of the instruction memory.
- MAX_WORDS, 256: largest accepted image in words; must be ≤ 2^ADDR_WIDTH.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets immediately).
- start  in  1  single-cycle re-arm pulse; honoured only in DONE or ERR.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  loader can accept a byte; a byte transfers when s_valid & s_ready.
- imem_we  out  1  single-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  word to write.
- core_hold  out  1  holds the pipeline in reset while high.
- done  out  1  image loaded and checksum good (level).
- error  out  1  length or checksum fault (level).
- word_count  out  16  count field of the current or last frame.

## Operation
- Frame format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4·N payload bytes, then CSUM.
- Each word's payload bytes arrive in order byte0 (bits 7:0) to byte3 (bits 31:24).
- CSUM equals the XOR of all payload bytes. Count bytes are excluded. With N=0, CSUM must be 0x00.
- States and transitions:
  - S_CLO: accept CNT_LO, then go to S_CHI.
  - S_CHI: accept CNT_HI and latch N into word_count. If N > MAX_WORDS, go to S_ERR. If N = 0, go to S_CSUM. Otherwise go to S_DATA.
  - S_DATA: accept payload bytes. A 2-bit byte counter and a word address counter track position. After byte3 of word N-1, go to S_CSUM.
  - S_CSUM: accept one byte. If it matches the running XOR, go to S_DONE; otherwise go to S_ERR.
  - S_DONE: set done=1 and core_hold=0. A start pulse clears done, the running XOR, word_count and the address counter, and goes to S_CLO with core_hold=1.
  - S_ERR: set error=1 and keep core_hold=1. A start pulse re-arms exactly as from S_DONE.
- s_ready is 1 in S_CLO, S_CHI, S_DATA and S_CSUM, and 0 in S_DONE and S_ERR. Bytes offered in S_DONE or S_ERR are not consumed.
- start outside S_DONE and S_ERR is ignored.
- Word write: on acceptance of byte3, the next cycle carries imem_we=1, imem_addr equal to the word index (0..N-1) and imem_wdata equal to the assembled word. The address counter then increments.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Address arithmetic is modulo 2^ADDR_WIDTH. Wrap cannot occur because N ≤ MAX_WORDS ≤ 2^ADDR_WIDTH.
- A transfer cycle with s_valid=0 changes nothing, so arbitrary bubbles are allowed between bytes.
- Reset values (async, reset=0): state S_CLO, s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, error=0, word_count=0, running XOR 0, byte counter 0.
- Reset mid-frame discards the partial frame. No write is issued for a partial word.

## Timing
- Throughput is 1 byte per cycle, so 1 word per 4 cycles at full rate. s_ready never deasserts mid-frame.
- imem_we fires exactly 1 cycle after the byte3 transfer. This gives N pulses per frame, never back-to-back at full rate.
- done and error rise 1 cycle after the CSUM transfer. core_hold falls in the same cycle that done rises.
- The last imem_we is at least 1 cycle before done rises.
- s_ready falls 1 cycle after the CSUM transfer, or 1 cycle after CNT_HI when N > MAX_WORDS.
- start in S_DONE or S_ERR: core_hold=1, done=0, error=0 and s_ready=1 all take effect the next cycle.
- start and s_valid in the same cycle while in S_DONE or S_ERR: no byte is consumed, because s_ready=0 that cycle.

## Test plan
- Full-rate load: frame 02 00 13 00 50 00 | 93 00 10 00 | C0. Expect writes addr0=0x00500013 and addr1=0x00100093. Expect done=1, core_hold=0, word_count=2, error=0.
- Bubbles: same frame with s_valid randomly low for 0–3 cycles between bytes. Expect identical writes and result, and no extra imem_we.
- Bad checksum: frame 01 00 AA BB CC DD | 00 (correct is 0x00, send 0x01). Expect one write addr0=0xDDCCBBAA, then error=1, done=0, core_hold=1, s_ready=0.
- Length fault: with MAX_WORDS=256, frame 01 01 (N=257). Expect no imem_we, error=1 the cycle after CNT_HI, s_ready=0 and word_count=0x0101.
- Zero-length frame and re-arm: frame 00 00 00 gives done=1 with no writes. Then a start pulse gives core_hold=1, done=0, s_ready=1. Then frame 01 00 01 02 03 04 04 gives write addr0=0x04030201 and done=1.
- Reset mid-frame: assert reset=0 after 6 bytes of a 2-word frame. Expect all outputs at reset values immediately, no write for the partial word. A fresh full frame afterwards loads correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: framed bytes -> little-endian words -> imem writes, XOR-checked; holds core until done.
// Latency: write 1 cycle after byte3, done/error 1 cycle after CSUM; s_ready drops only in DONE/ERR.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  imem_loader_if.slave bus,
  output logic        o_core_hold,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_word_count
);

  typedef enum logic [2:0] {
    S_CLO, S_CHI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t                r_state;
  logic [7:0]            r_cnt_lo;
  logic [15:0]           r_word_count;
  logic [7:0]            r_xor;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_word_buf;
  logic [15:0]           r_widx;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_error;

  logic        w_xfer;
  logic [15:0] w_n;
  logic [15:0] w_widx_next;

  assign w_xfer      = bus.s_valid & r_ready;
  assign w_n         = {bus.s_data, r_cnt_lo};
  assign w_widx_next = r_widx + 16'd1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_CLO;
      r_cnt_lo     <= '0;
      r_word_count <= '0;
      r_xor        <= '0;
      r_byte_cnt   <= '0;
      r_word_buf   <= '0;
      r_widx       <= '0;
      r_ready      <= 1'b1;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_hold       <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_CLO: if (w_xfer) begin
          r_cnt_lo <= bus.s_data;
          r_state  <= S_CHI;
        end
        S_CHI: if (w_xfer) begin
          r_word_count <= w_n;
          if ({1'b0, w_n} > MAX_N) begin
            r_state <= S_ERR;
            r_ready <= 1'b0;
            r_error <= 1'b1;
          end else if (w_n == 16'd0) begin
            r_state <= S_CSUM;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_xfer) begin
          r_xor      <= r_xor ^ bus.s_data;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0: r_word_buf[7:0]   <= bus.s_data;
            2'd1: r_word_buf[15:8]  <= bus.s_data;
            2'd2: r_word_buf[23:16] <= bus.s_data;
            default: begin
              r_we    <= 1'b1;
              r_waddr <= r_widx[ADDR_WIDTH-1:0];
              r_wdata <= {bus.s_data, r_word_buf};
              r_widx  <= w_widx_next;
              if (w_widx_next == r_word_count) r_state <= S_CSUM;
            end
          endcase
        end
        S_CSUM: if (w_xfer) begin
          r_ready <= 1'b0;
          if (bus.s_data == r_xor) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
          end else begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end
        end
        S_DONE, S_ERR: if (i_start) begin
          // Re-arm: write port keeps its last address/data.
          r_state      <= S_CLO;
          r_ready      <= 1'b1;
          r_hold       <= 1'b1;
          r_done       <= 1'b0;
          r_error      <= 1'b0;
          r_xor        <= '0;
          r_word_count <= '0;
          r_widx       <= '0;
          r_byte_cnt   <= '0;
        end
        default: r_state <= S_CLO;
      endcase
    end
  end

  assign bus.s_ready    = r_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign o_core_hold    = r_hold;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frames against a frame-level reference model of the loader.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        core_hold, done, error;
  logic [15:0] word_count;

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .bus(bus.slave),
    .o_core_hold(core_hold), .o_done(done), .o_error(error), .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int b2b_cnt = 0;
  logic prev_we = 1'b0;

  logic [7:0]  fq[$];
  logic [7:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_ok;
  logic [15:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_addr.push_back(bus.imem_addr);
      obs_data.push_back(bus.imem_wdata);
      if (prev_we) b2b_cnt++;
    end
    prev_we <= (bus.imem_we === 1'b1);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: interpret the whole frame at once.
  function automatic void model();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = {fq[1], fq[0]};
    exp_cnt = 16'(n);
    if (n > 256) begin
      exp_ok = 0;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(8'(w % 256));
      exp_data.push_back({fq[2+4*w+3], fq[2+4*w+2], fq[2+4*w+1], fq[2+4*w]});
      for (int b = 0; b < 4; b++) x = x ^ fq[2+4*w+b];
    end
    exp_ok = (fq[2+4*n] == x);
  endfunction

  function automatic void build_frame(input int n, input bit corrupt);
    logic [7:0] x, b;
    fq.delete();
    fq.push_back(8'(n));
    fq.push_back(8'(n >> 8));
    if (n > 256) return;
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(255, 0));
      fq.push_back(b);
      x = x ^ b;
    end
    fq.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
  endfunction

  task automatic push(input logic [7:0] b, input bit st);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    start       = st;
    while (bus.s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("push_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    start       = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int max_bub, input bit poke_start);
    int k;
    obs_addr.delete();
    obs_data.delete();
    model();
    for (int i = 0; i < fq.size(); i++) begin
      k = (max_bub > 0) ? int'($urandom_range(max_bub, 0)) : 0;
      repeat (k) @(negedge clk);
      push(fq[i], poke_start && i == 3);
    end
    chk({nm, "_done"},  done,       exp_ok);
    chk({nm, "_error"}, error,      !exp_ok);
    chk({nm, "_hold"},  core_hold,  !exp_ok);
    chk({nm, "_ready"}, bus.s_ready, 1'b0);
    chk({nm, "_wcnt"},  word_count, exp_cnt);
    @(negedge clk);
    chk({nm, "_nwr"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk({nm, "_waddr"}, obs_addr[i], exp_addr[i]);
      chk({nm, "_wdata"}, obs_data[i], exp_data[i]);
    end
  endtask

  task automatic rearm();
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'($urandom_range(255, 0));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    chk("arm_hold",  core_hold,   1'b1);
    chk("arm_done",  done,        1'b0);
    chk("arm_error", error,       1'b0);
    chk("arm_ready", bus.s_ready, 1'b1);
    chk("arm_wcnt",  word_count,  16'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, bus.s_ready,    1'b1);
    chk({nm, "_we"},    bus.imem_we,    1'b0);
    chk({nm, "_addr"},  bus.imem_addr,  8'd0);
    chk({nm, "_wdata"}, bus.imem_wdata, 32'd0);
    chk({nm, "_hold"},  core_hold,      1'b1);
    chk({nm, "_done"},  done,           1'b0);
    chk({nm, "_error"}, error,          1'b0);
    chk({nm, "_wcnt"},  word_count,     16'd0);
  endtask

  initial begin
    int n;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    fq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    run_frame("full", 0, 1'b0);
    if (obs_data.size() == 2) begin
      chk("full_w0", obs_data[0], 32'h00500013);
      chk("full_w1", obs_data[1], 32'h00100093);
    end else chk("full_cnt", obs_data.size(), 2);

    rearm();
    run_frame("bub", 3, 1'b0);

    rearm();
    fq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
    run_frame("badcs", 0, 1'b0);
    chk("badcs_error_lit", error, 1'b1);

    rearm();
    fq = '{8'h01, 8'h01};
    run_frame("len", 0, 1'b0);
    chk("len_wcnt_lit", word_count, 16'h0101);

    rearm();
    fq = '{8'h00, 8'h00, 8'h00};
    run_frame("zero", 0, 1'b0);
    rearm();
    fq = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_frame("after_arm", 1, 1'b0);
    if (obs_data.size() == 1) chk("after_arm_w0", obs_data[0], 32'h04030201);

    rearm();
    build_frame(256, 1'b0);
    run_frame("max", 0, 1'b0);

    rearm();
    build_frame(2, 1'b0);
    obs_addr.delete();
    obs_data.delete();
    for (int i = 0; i < 6; i++) push(fq[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk("midrst_nwr", obs_addr.size(), 1);
    rst_n = 1'b1;
    build_frame(2, 1'b0);
    run_frame("post_rst", 0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(9, 0))
        0: n = 257 + int'($urandom_range(300, 0));
        1: n = 0;
        default: n = int'($urandom_range(6, 1));
      endcase
      rearm();
      build_frame(n, $urandom_range(3, 0) == 0);
      run_frame("rnd", int'($urandom_range(3, 0)), $urandom_range(1, 0) == 1);
    end

    chk("b2b_we", b2b_cnt, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
